ram_arbiter: RTL

//   Parametrised multi-client front end for the single-port synchronous working RAM (S-box).

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: front end for the single-port working RAM. It launches one host-selected client
// engine, gives that client exclusive RAM access, tags read returns, and reports finish or timeout.
module ram_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_CLIENTS    = 3,
    parameter int MODE_WIDTH     = 3,
    parameter int RAM_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [MODE_WIDTH-1:0]            mode,
    input  logic                             start,
    output logic                             busy,
    output logic                             finished,
    output logic                             error,
    output logic [NUM_CLIENTS-1:0]           client_start,
    input  logic [NUM_CLIENTS-1:0]           client_done,
    input  logic [NUM_CLIENTS-1:0]           client_wren,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wdata,
    output logic [DATA_WIDTH-1:0]            client_rdata,
    output logic [NUM_CLIENTS-1:0]           client_rvalid,
    output logic                             ram_wren,
    output logic [ADDR_WIDTH-1:0]            ram_address,
    output logic [DATA_WIDTH-1:0]            ram_data,
    input  logic [DATA_WIDTH-1:0]            ram_q
);

    localparam int SEL_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SEL_W-1:0]        sel;
    logic [CNT_W-1:0]        timeout_cnt;
    logic [RAM_LATENCY-1:0]  pipe_valid;
    logic [SEL_W-1:0]        pipe_sel [RAM_LATENCY];

    logic                    mode_legal;
    logic                    sel_done;
    logic                    sel_wren;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    timeout_hit;

    assign mode_legal  = (mode != '0) && (int'(mode) <= NUM_CLIENTS);
    assign sel_done    = client_done[sel];
    assign sel_wren    = client_wren[sel];
    assign sel_addr    = client_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata   = client_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
    // The last RUN cycle before abort is the one where the counter holds TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE:   if (start && mode_legal) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_RUN;
            S_RUN:    if (sel_done || timeout_hit) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == S_LAUNCH) || (state == S_RUN);
        client_start = '0;
        ram_wren     = 1'b0;
        ram_address  = '0;
        ram_data     = '0;
        if (state == S_LAUNCH) begin
            client_start[sel] = 1'b1;
        end
        if (state == S_RUN) begin
            ram_wren    = sel_wren;
            ram_address = sel_addr;
            ram_data    = sel_wdata;
        end
        client_rvalid = '0;
        if (pipe_valid[RAM_LATENCY-1]) begin
            client_rvalid[pipe_sel[RAM_LATENCY-1]] = 1'b1;
        end
    end

    assign client_rdata = ram_q;

    // Done takes priority over a coincident timeout, so the two pulses are exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel         <= '0;
            timeout_cnt <= '0;
            finished    <= 1'b0;
            error       <= 1'b0;
            pipe_valid  <= '0;
        end else begin
            finished <= (state == S_RUN) && sel_done;
            error    <= ((state == S_IDLE) && start && !mode_legal)
                     || ((state == S_RUN) && !sel_done && timeout_hit);
            if ((state == S_IDLE) && start && mode_legal) begin
                sel <= SEL_W'(int'(mode) - 1);
            end
            if (state == S_LAUNCH) begin
                timeout_cnt <= '0;
            end else if (state == S_RUN) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
            pipe_valid[0] <= (state == S_RUN) && !sel_wren;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // NOTE: the tag pipeline is not reset; a tag is only looked at while its valid bit is set.
    always_ff @(posedge clk) begin
        pipe_sel[0] <= sel;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_sel[i] <= pipe_sel[i-1];
        end
    end

endmodule
